// File: rtl/imm_ext_pkg.sv
// Shared opcode, extension-mode and beat definitions for the immediate-extension controller.
package imm_ext_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned MODE_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [MODE_W-1:0] {
    EXT_NONE  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_SIGN  = 2'd2,
    EXT_UPPER = 2'd3
  } ext_mode_e;

  // One decoded beat as held in the output and skid registers.
  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [MODE_W-1:0] mode;
    logic              illegal;
  } imm_beat_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational opcode decode: selects zero/sign/upper extension of instr[15:0].
module imm_ext_decode
  import imm_ext_pkg::*;
#(
  parameter int unsigned ENABLE_BRANCH_SHIFT = 0
) (
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm_32,
  output logic [MODE_W-1:0] ext_mode,
  output logic              illegal
);

  localparam bit SHIFT_BR = (ENABLE_BRANCH_SHIFT != 0);

  logic [OPC_W-1:0]  opcode;
  logic [IMM_W-1:0]  field;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;

  assign opcode = instr[DATA_W-1 -: OPC_W];
  assign field  = instr[IMM_W-1:0];
  assign zext   = {{(DATA_W-IMM_W){1'b0}}, field};
  assign sext   = {{(DATA_W-IMM_W){field[IMM_W-1]}}, field};

  always_comb begin
    imm_32   = '0;
    ext_mode = EXT_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: begin
        imm_32   = zext;
        ext_mode = EXT_ZERO;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        imm_32   = sext;
        ext_mode = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        // Optional word-offset scaling for branch targets; top bits drop off.
        imm_32   = SHIFT_BR ? {sext[DATA_W-3:0], 2'b00} : sext;
        ext_mode = EXT_SIGN;
      end
      OP_LUI: begin
        imm_32   = {field, {(DATA_W-IMM_W){1'b0}}};
        ext_mode = EXT_UPPER;
      end
      OP_RTYPE, OP_J, OP_JAL: begin
        imm_32   = '0;
      end
      default: begin
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate-extension controller with a 2-entry skid buffer toward execute.
module imm_ext_ctrl
  import imm_ext_pkg::*;
#(
  parameter int unsigned CNT_W               = 16,
  parameter int unsigned ENABLE_BRANCH_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_32,
  output logic [MODE_W-1:0] ext_mode,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] dec_imm;
  logic [MODE_W-1:0] dec_mode;
  logic              dec_illegal;
  imm_beat_t         dec_beat;

  imm_ext_decode #(
    .ENABLE_BRANCH_SHIFT(ENABLE_BRANCH_SHIFT)
  ) u_decode (
    .instr    (instr),
    .imm_32   (dec_imm),
    .ext_mode (dec_mode),
    .illegal  (dec_illegal)
  );

  assign dec_beat = '{imm: dec_imm, mode: dec_mode, illegal: dec_illegal};

  buf_state_e       state_q;
  buf_state_e       state_d;
  imm_beat_t        out_q;
  imm_beat_t        skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic drain;
  logic load_out;
  logic load_skid;
  logic out_from_skid;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // Buffer occupancy: output register first, skid register only when it is busy.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d  = BUF_ONE;
          load_out = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !drain) begin
          state_d   = BUF_TWO;
          load_skid = 1'b1;
        end else if (!accept && drain) begin
          state_d   = BUF_EMPTY;
        end else if (accept && drain) begin
          load_out  = 1'b1;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          state_d       = BUF_ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_TWO);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  // Beat registers and the accept-time illegal counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_out) begin
        out_q <= out_from_skid ? skid_q : dec_beat;
      end
      if (load_skid) begin
        skid_q <= dec_beat;
      end
      if (accept && dec_beat.illegal && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign imm_32      = out_q.imm;
  assign ext_mode    = out_q.mode;
  assign illegal     = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Self-checking bench for imm_ext_ctrl: vector table, directed handshake cases, random traffic vs queue model.
module tb_imm_ext_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] imm_a;
  logic [1:0]  mode_a;
  logic [3:0]  cnt_a;

  logic        in_ready_b, out_valid_b, illegal_b;
  logic [31:0] imm_b;
  logic [1:0]  mode_b;
  logic [15:0] cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_ext_ctrl #(.CNT_W(4), .ENABLE_BRANCH_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_32(imm_a), .ext_mode(mode_a), .illegal(illegal_a), .illegal_cnt(cnt_a)
  );

  imm_ext_ctrl #(.CNT_W(16), .ENABLE_BRANCH_SHIFT(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_32(imm_b), .ext_mode(mode_b), .illegal(illegal_b), .illegal_cnt(cnt_b)
  );

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic        ill;
  } beat_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  mode;
    logic        ill;
    logic [31:0] imm_shift;
  } vec_t;

  beat_t mq[$];
  beat_t mb[$];
  int    cnt_ma = 0;
  int    cnt_mb = 0;

  // Reference extension computed arithmetically from the opcode class.
  function automatic beat_t ref_decode(input logic [31:0] w, input bit shift);
    beat_t       b;
    logic [31:0] u;
    logic [31:0] s;
    u = 32'(w[15:0]);
    s = (u >= 32'h8000) ? u - 32'h10000 : u;
    b.imm = 32'h0; b.mode = 2'd0; b.ill = 1'b0;
    case (w[31:26])
      6'b001100, 6'b001101, 6'b001110: begin b.imm = u; b.mode = 2'd1; end
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011: begin
        b.imm = s; b.mode = 2'd2;
      end
      6'b000100, 6'b000101: begin b.imm = shift ? s * 32'd4 : s; b.mode = 2'd2; end
      6'b001111: begin b.imm = u * 32'h10000; b.mode = 2'd3; end
      6'b000000, 6'b000010, 6'b000011: ;
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid_a), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready_a), 32'(mq.size() < 2));
    chk("out_valid_b", 32'(out_valid_b), 32'(mb.size() > 0));
    if (mq.size() > 0) begin
      chk("imm", imm_a, mq[0].imm);
      chk("mode", 32'(mode_a), 32'(mq[0].mode));
      chk("illegal", 32'(illegal_a), 32'(mq[0].ill));
      chk("imm_b", imm_b, mb[0].imm);
    end
    chk("cnt", 32'(cnt_a), 32'(cnt_ma));
    chk("cnt_b", 32'(cnt_b), 32'(cnt_mb));
  endtask

  // Check current outputs, then advance one clock and update the FIFO model.
  task automatic tick();
    bit    acc;
    bit    drn;
    beat_t ba;
    beat_t bb;
    check_model();
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    ba  = ref_decode(instr, 1'b0);
    bb  = ref_decode(instr, 1'b1);
    @(posedge clk);
    #1;
    if (drn) begin
      void'(mq.pop_front());
      void'(mb.pop_front());
    end
    if (acc) begin
      mq.push_back(ba);
      mb.push_back(bb);
      if (ba.ill) begin
        if (cnt_ma < 15) cnt_ma++;
        if (cnt_mb < 65535) cnt_mb++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    logic [5:0]  ops[16];

    vecs[0]  = '{32'h7C00_0000, 32'h0000_0000, 2'd0, 1'b1, 32'h0000_0000};
    vecs[1]  = '{32'h3421_8001, 32'h0000_8001, 2'd1, 1'b0, 32'h0000_8001};
    vecs[2]  = '{32'h2021_8001, 32'hFFFF_8001, 2'd2, 1'b0, 32'hFFFF_8001};
    vecs[3]  = '{32'h3C01_1234, 32'h1234_0000, 2'd3, 1'b0, 32'h1234_0000};
    vecs[4]  = '{32'h3000_00FF, 32'h0000_00FF, 2'd1, 1'b0, 32'h0000_00FF};
    vecs[5]  = '{32'hAC00_FFFC, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'hFFFF_FFFC};
    vecs[6]  = '{32'h1000_FFFF, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'hFFFF_FFFC};
    vecs[7]  = '{32'h0000_0020, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_0000};
    vecs[8]  = '{32'h0800_1234, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h3800_8000, 32'h0000_8000, 2'd1, 1'b0, 32'h0000_8000};
    vecs[10] = '{32'h8C00_7FFF, 32'h0000_7FFF, 2'd2, 1'b0, 32'h0000_7FFF};
    vecs[11] = '{32'h1400_8000, 32'hFFFF_8000, 2'd2, 1'b0, 32'hFFFE_0000};

    ops = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001001,
            6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
            6'b100011, 6'b101011, 6'b111111, 6'b010001};

    reset = 1'b1; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_imm", imm_a, 32'h0);
    chk("rst_mode", 32'(mode_a), 32'd0);
    chk("rst_illegal", 32'(illegal_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Single-beat vectors with out_ready high: one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      chk("vec_valid", 32'(out_valid_a), 32'd1);
      chk("vec_imm", imm_a, vecs[i].imm);
      chk("vec_mode", 32'(mode_a), 32'(vecs[i].mode));
      chk("vec_illegal", 32'(illegal_a), 32'(vecs[i].ill));
      chk("vec_imm_shift", imm_b, vecs[i].imm_shift);
      if (i == 0) chk("cnt_first_illegal", 32'(cnt_a), 32'd1);
      tick();
    end

    // Back-to-back ADDI then LUI.
    in_valid = 1'b1; instr = 32'h2021_8001;
    tick();
    instr = 32'h3C01_1234;
    chk("b2b_imm0", imm_a, 32'hFFFF_8001);
    chk("b2b_mode0", 32'(mode_a), 32'd2);
    tick();
    in_valid = 1'b0;
    chk("b2b_imm1", imm_a, 32'h1234_0000);
    chk("b2b_mode1", 32'(mode_a), 32'd3);
    tick();

    // Backpressure: two accepts fill the buffer, third waits, strict order on release.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h3000_00FF;
    tick();
    instr = 32'hAC00_FFFC;
    tick();
    instr = 32'h3400_0001;
    chk("bp_full_in_ready", 32'(in_ready_a), 32'd0);
    tick();
    chk("bp_hold_in_ready", 32'(in_ready_a), 32'd0);
    chk("bp_first", imm_a, 32'h0000_00FF);
    out_ready = 1'b1;
    tick();
    chk("bp_second", imm_a, 32'hFFFF_FFFC);
    chk("bp_reopen", 32'(in_ready_a), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third", imm_a, 32'h0000_0001);
    tick();
    chk("bp_empty", 32'(out_valid_a), 32'd0);

    // Saturation of the 4-bit counter.
    in_valid = 1'b1; instr = 32'h7C00_0000;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("cnt_sat", 32'(cnt_a), 32'd15);
    tick();

    // Asynchronous reset while the buffer holds two beats.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h3421_8001;
    tick();
    instr = 32'h3000_00FF;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_full", 32'(in_ready_a), 32'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid_a), 32'd0);
    chk("arst_in_ready", 32'(in_ready_a), 32'd1);
    chk("arst_cnt", 32'(cnt_a), 32'd0);
    chk("arst_imm", imm_a, 32'h0);
    mq.delete(); mb.delete(); cnt_ma = 0; cnt_mb = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(out_valid_a), 32'd0);
    in_valid = 1'b1; instr = 32'h3C01_1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid_a), 32'd1);
    chk("post_rst_imm", imm_a, 32'h1234_0000);
    tick();

    // Random traffic; a stalled beat is held until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && (mq.size() >= 2))) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = {ops[$urandom_range(0, 15)], 26'($urandom)};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("final_empty", 32'(out_valid_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
